rr_arbiter4_ctrl: RTL and testbench

- Registered 4-way round-robin arbiter that shares one downstream resource between four requesters.
- Tracks the priority pointer and walks the search order with 2-bit unsigned increment units (macro_rom_incr2 instances; carry ignored, so the index wraps 3 -> 0).
- Grant is held with a valid/ready handshake until the downstream consumer accepts it.
- Used in front of shared single-port resources in the core (e.g. shared memory port, CSR bus).

---
 rtl/rr_arbiter4_ctrl.sv | 123 ++++++++++++
 tb/tb_rr_arbiter4_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4_ctrl.sv
// Registered 4-way round-robin arbiter with valid/ready grant hold.
// Optional grant lock across accepts is enabled by defining RR_ARBITER4_CTRL_LOCK_EN.

module macro_rom_incr2 (
   input  logic [1:0] a,
   output logic [1:0] y
);
   assign y = a + 2'd1;
endmodule

module rr_arbiter4_ctrl #(
   parameter logic [1:0] RESET_PTR = 2'd0
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   input  logic       gnt_ready,
   input  logic       lock,
   output logic [1:0] ptr
);
   // state | meaning
   // IDLE  | no grant outstanding, searching from r_ptr each cycle
   // GRANT | grant r_gnt_idx held until accepted by the consumer
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_gnt_idx, w_gnt_idx_nxt;
   logic       r_gnt_valid, w_gnt_valid_nxt;
   logic [1:0] r_ptr, w_ptr_nxt;

   logic       w_accept;
   logic [1:0] w_idx_inc;
   logic [1:0] w_ord0, w_ord1, w_ord2, w_ord3;
   logic       w_win_found;
   logic [1:0] w_win_idx;
   logic       w_hold_lock;

   assign w_accept = r_gnt_valid & gnt_ready;

   macro_rom_incr2 u_inc_gnt (.a(r_gnt_idx), .y(w_idx_inc));

   // After an accept the search starts just past the accepted index (back-to-back).
   assign w_ord0 = r_gnt_valid ? w_idx_inc : r_ptr;

   macro_rom_incr2 u_inc_ord1 (.a(w_ord0), .y(w_ord1));
   macro_rom_incr2 u_inc_ord2 (.a(w_ord1), .y(w_ord2));
   macro_rom_incr2 u_inc_ord3 (.a(w_ord2), .y(w_ord3));

   always_comb begin
      w_win_found = 1'b1;
      w_win_idx   = 2'd0;
      if (req[w_ord0])      w_win_idx = w_ord0;
      else if (req[w_ord1]) w_win_idx = w_ord1;
      else if (req[w_ord2]) w_win_idx = w_ord2;
      else if (req[w_ord3]) w_win_idx = w_ord3;
      else                  w_win_found = 1'b0;
   end

`ifdef RR_ARBITER4_CTRL_LOCK_EN
   assign w_hold_lock = lock;
`else
   logic w_unused_lock;
   assign w_unused_lock = lock;
   assign w_hold_lock   = 1'b0;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_idx_nxt   = r_gnt_idx;
      w_gnt_valid_nxt = r_gnt_valid;
      w_ptr_nxt       = r_ptr;
      case (r_state)
         IDLE: begin
            if (w_win_found) begin
               w_state_nxt     = GRANT;
               w_gnt_idx_nxt   = w_win_idx;
               w_gnt_valid_nxt = 1'b1;
            end
         end
         GRANT: begin
            if (w_accept && !w_hold_lock) begin
               w_ptr_nxt = w_idx_inc;
               if (w_win_found) begin
                  w_gnt_idx_nxt = w_win_idx;
               end else begin
                  w_state_nxt     = IDLE;
                  w_gnt_idx_nxt   = 2'd0;
                  w_gnt_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_gnt_idx_nxt   = 2'd0;
            w_gnt_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_gnt_idx   <= 2'd0;
         r_gnt_valid <= 1'b0;
         r_ptr       <= RESET_PTR;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt_idx   <= w_gnt_idx_nxt;
         r_gnt_valid <= w_gnt_valid_nxt;
         r_ptr       <= w_ptr_nxt;
      end
   end

   // Decoding from registered index/valid keeps gnt one-hot or zero by construction.
   assign gnt       = {4{r_gnt_valid}} & (4'b0001 << r_gnt_idx);
   assign gnt_idx   = r_gnt_idx;
   assign gnt_valid = r_gnt_valid;
   assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_arbiter4_ctrl.sv
// Directed bench for rr_arbiter4_ctrl; lock steps follow RR_ARBITER4_CTRL_LOCK_EN.

module tb_rr_arbiter4_ctrl;
   logic       clk = 1'b0;
   logic       resetn;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       gnt_ready;
   logic       lock;
   logic [1:0] ptr;

   int n_chk = 0;
   int n_err = 0;

   rr_arbiter4_ctrl #(.RESET_PTR(2'd0)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .gnt_ready (gnt_ready),
      .lock      (lock),
      .ptr       (ptr)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic ev, input logic [1:0] ei, input logic [1:0] ep);
      logic [3:0] eg;
      eg = ev ? (4'b0001 << ei) : 4'b0000;
      n_chk += 4;
      assert (gnt === eg) else begin
         n_err++;
         $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
      end
      assert (gnt_valid === ev) else begin
         n_err++;
         $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, ev);
      end
      assert (gnt_idx === (ev ? ei : 2'd0)) else begin
         n_err++;
         $error("FAIL %s gnt_idx got=%0d exp=%0d", tag, gnt_idx, (ev ? ei : 2'd0));
      end
      assert (ptr === ep) else begin
         n_err++;
         $error("FAIL %s ptr got=%0d exp=%0d", tag, ptr, ep);
      end
   endtask

   initial begin
      resetn    = 1'b0;
      req       = 4'b1111;
      gnt_ready = 1'b0;
      lock      = 1'b0;
      #2;
      chk("reset_async", 1'b0, 2'd0, 2'd0);
      cyc();
      cyc();
      chk("reset_held", 1'b0, 2'd0, 2'd0);
      @(negedge clk);
      resetn = 1'b1;
      cyc();
      chk("first_grant", 1'b1, 2'd0, 2'd0);

      // full contention, accept every cycle
      gnt_ready = 1'b1;
      cyc(); chk("rr_1", 1'b1, 2'd1, 2'd1);
      cyc(); chk("rr_2", 1'b1, 2'd2, 2'd2);
      cyc(); chk("rr_3", 1'b1, 2'd3, 2'd3);
      cyc(); chk("rr_0", 1'b1, 2'd0, 2'd0);
      cyc(); chk("rr_1b", 1'b1, 2'd1, 2'd1);
      cyc(); chk("rr_2b", 1'b1, 2'd2, 2'd2);

      // drain to idle with ptr = 3
      req = 4'b0000;
      cyc(); chk("drain_idle", 1'b0, 2'd0, 2'd3);
      cyc(); chk("idle_ready_ignored", 1'b0, 2'd0, 2'd3);

      // wrap/skip from ptr 3
      gnt_ready = 1'b0;
      req = 4'b0110;
      cyc(); chk("wrap_skip", 1'b1, 2'd1, 2'd3);
      gnt_ready = 1'b1;
      cyc(); chk("wrap_accept", 1'b1, 2'd2, 2'd2);

      // backpressure with changing requests
      gnt_ready = 1'b0;
      req = 4'b1001;
      for (int i = 0; i < 5; i++) begin
         cyc(); chk("bp_hold", 1'b1, 2'd2, 2'd2);
      end
      gnt_ready = 1'b1;
      cyc(); chk("bp_accept", 1'b1, 2'd3, 2'd3);

      // single requester wins every accept
      req = 4'b0100;
      cyc(); chk("single_1", 1'b1, 2'd2, 2'd0);
      cyc(); chk("single_2", 1'b1, 2'd2, 2'd3);
      cyc(); chk("single_3", 1'b1, 2'd2, 2'd3);
      req = 4'b0000;
      cyc(); chk("single_idle", 1'b0, 2'd0, 2'd3);

      // lock behaviour
      gnt_ready = 1'b0;
      req = 4'b0010;
      cyc(); chk("lock_setup", 1'b1, 2'd1, 2'd3);
      req = 4'b1111;
      lock = 1'b1;
      gnt_ready = 1'b1;
`ifdef RR_ARBITER4_CTRL_LOCK_EN
      cyc(); chk("lock_acc1", 1'b1, 2'd1, 2'd3);
      cyc(); chk("lock_acc2", 1'b1, 2'd1, 2'd3);
      cyc(); chk("lock_acc3", 1'b1, 2'd1, 2'd3);
      lock = 1'b0;
      cyc(); chk("lock_release", 1'b1, 2'd2, 2'd2);
`else
      cyc(); chk("lock_ignored", 1'b1, 2'd2, 2'd2);
      cyc(); chk("lock_ignored2", 1'b1, 2'd3, 2'd3);
      lock = 1'b0;
`endif

      // reset in the middle of a grant with ready high
      resetn = 1'b0;
      #1;
      chk("reset_mid_grant", 1'b0, 2'd0, 2'd0);
      cyc();
      chk("reset_mid_hold", 1'b0, 2'd0, 2'd0);
      @(negedge clk);
      resetn = 1'b1;
      gnt_ready = 1'b0;
      req = 4'b1000;
      cyc(); chk("post_reset", 1'b1, 2'd3, 2'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
